ir_fetch_ctrl: RTL and testbench
================================

Name: ir_fetch_ctrl

Overview:
Multi-cycle instruction fetch sequencer that sits directly upstream of the instruction register.
- Reads one 32-bit instruction as four bytes over the 8-bit memory bus, starting at the current PC.
- Drives the IR's rw and one-hot ir_write byte strobes so each byte is captured on the clock edge its data is valid.
- Owns the PC: advances it by 4 per completed fetch and accepts redirects from the control unit.

Parameters:
- ADDR_W, 16, width of PC and memory byte address.
- RESET_PC, 0, PC value after reset; must be a multiple of 4.
- TIMEOUT_CYC, 15, maximum wait cycles per byte before abort (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  request to fetch the instruction at pc; sampled in IDLE only.
- stall  in  1  when high, blocks a fetch from starting in IDLE.
- pc_load  in  1  redirect strobe.
- pc_load_val  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0.
- mem_addr  out  ADDR_W  byte address presented to memory.
- mem_rd  out  1  memory read enable.
- mem_ready  in  1  memory data_in is valid this cycle.
- rw  out  1  to the IR; 0 = read/capture, 1 = hold.
- ir_write  out  4  to the IR; one-hot byte-lane strobe.
- fetch_done  out  1  one-cycle pulse: all 4 IR bytes are captured.
- busy  out  1  high in any state other than IDLE.
- pc  out  ADDR_W  current instruction address.
- fetch_err  out  1  timeout abort pulse; tied to 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_n low), effective immediately regardless of state:
  - state = IDLE, pc = RESET_PC, byte_idx = 0.
  - mem_rd = 0, rw = 1, ir_write = 0000, fetch_done = 0, busy = 0, fetch_err = 0, mem_addr = RESET_PC.
- State machine: IDLE, REQ, DONE.
- IDLE:
  - If pc_load: pc <= {pc_load_val[ADDR_W-1:2], 2'b00}; stay in IDLE.
  - Else if fetch_req && !stall: byte_idx <= 0; go to REQ.
- REQ:
  - mem_rd = 1, rw = 0, mem_addr = pc + byte_idx (modulo 2^ADDR_W).
  - ir_write = (1 << byte_idx) combinationally while mem_ready = 1, else 0000. The strobe and valid data are therefore coincident in the same cycle.
  - On mem_ready: byte_idx increments. If byte_idx was 3, go to DONE.
  - Without mem_ready: hold all state (wait states allowed indefinitely).
- Byte order is little-endian: address pc+k loads IR lane k (ir_write bit k). Lane 3 therefore carries opcode/RS bits [31:24].
- DONE:
  - mem_rd = 0, rw = 1, ir_write = 0000, fetch_done = 1.
  - pc <= pc + 4 (wraps modulo 2^ADDR_W); go to IDLE.
- Latency with zero-wait memory:
  - fetch_req sampled at edge 0; REQ occupies cycles 1–4; fetch_done is high in cycle 5.
  - The new pc is visible in cycle 6.
  - Each wait state adds one cycle.
- pc_load in REQ or DONE:
  - Aborts the fetch and goes to IDLE next cycle; ir_write is not asserted in the load cycle.
  - pc takes the redirect target; the redirect has priority over the DONE increment.
  - fetch_done is suppressed in that cycle.
- stall has no effect once in REQ or DONE.
- Simultaneous fetch_req and pc_load in IDLE: the load wins and the fetch is not started.
- Partially written IR contents after an abort are don't-care; only fetch_done qualifies the IR.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A per-byte wait counter clears on entering REQ and on each mem_ready, and increments each REQ cycle without mem_ready.
  - When the count reaches TIMEOUT_CYC: pulse fetch_err for 1 cycle, go to IDLE, pc unchanged, no fetch_done.
  - pc_load still has priority over the timeout.
- FETCH_TIMEOUT_EN undefined: no counter; fetch_err is constant 0; REQ waits forever.

Decomposition:
- Shared package fetch_pkg:
  - State enum (IDLE, REQ, DONE).
  - Lane constants LANE0..LANE3 = 4'b0001..4'b1000.
  - RW_READ = 0, RW_HOLD = 1.
  - INSTR_BYTES = 4.
- No sub-module; the FSM, PC and timeout counter are small enough to remain in one module.

Test Plan:
- Zero-wait fetch, pc = 0x0000, memory bytes 0x78, 0x56, 0x34, 0x12 at 0..3:
  - ir_write sequence is 0001, 0010, 0100, 1000 in cycles 1–4.
  - fetch_done pulses in cycle 5; IR = 0x12345678; pc = 0x0004 in cycle 6.
- One wait state on byte 2:
  - mem_addr holds 0x0002 for 2 cycles; ir_write = 0000 in the wait cycle.
  - fetch_done moves to cycle 6.
- Redirect:
  - pc_load with pc_load_val = 0x0123 while in REQ at byte 1: next state IDLE, pc = 0x0120, no fetch_done.
  - A following fetch reads addresses 0x0120–0x0123.
- Wrap and arbitration:
  - pc = 0xFFFC fetch reads 0xFFFC–0xFFFF, then pc = 0x0000.
  - stall = 1 with fetch_req = 1 in IDLE: busy stays 0 and mem_rd stays 0.
- Reset mid-operation (and timeout):
  - rst_n low in REQ at byte 2: outputs return to reset values immediately, without waiting for an edge.
  - With FETCH_TIMEOUT_EN, holding mem_ready = 0 for 15 cycles produces one fetch_err pulse and a return to IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-register fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam logic [3:0] LANE0 = 4'b0001;
    localparam logic [3:0] LANE1 = 4'b0010;
    localparam logic [3:0] LANE2 = 4'b0100;
    localparam logic [3:0] LANE3 = 4'b1000;

    localparam logic RW_READ = 1'b0;
    localparam logic RW_HOLD = 1'b1;

    localparam int INSTR_BYTES = 4;

    // Byte address pc+k lands in IR lane k (little-endian).
    function automatic logic [3:0] lane_strobe(input logic [1:0] idx);
        logic [3:0] s;
        case (idx)
            2'd0:    s = LANE0;
            2'd1:    s = LANE1;
            2'd2:    s = LANE2;
            default: s = LANE3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ir_fetch_ctrl.sv
// Four-byte instruction fetch sequencer driving the IR byte strobes and owning the PC.
// Optional per-byte wait timeout enabled by defining FETCH_TIMEOUT_EN.
module ir_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic              stall,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    output logic              rw,
    output logic [3:0]        ir_write,
    output logic              fetch_done,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic              timeout;
    logic              unused_lsbs;

    assign unused_lsbs = ^pc_load_val[1:0];

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counter stays clear outside REQ, so entering REQ always starts from zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout    = 1'b0;
        if (state_q != ST_REQ || mem_ready || pc_load) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout    = 1'b1;
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign fetch_err = timeout;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // A redirect overrides every state, including the DONE increment.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_idx_d = byte_idx_q;
        if (pc_load) begin
            pc_d       = {pc_load_val[ADDR_W-1:2], 2'b00};
            state_d    = ST_IDLE;
            byte_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_req && !stall) begin
                        byte_idx_d = '0;
                        state_d    = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (timeout) begin
                        byte_idx_d = '0;
                        state_d    = ST_IDLE;
                    end else if (mem_ready) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d    = ST_IDLE;
                    byte_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // byte_idx is zero outside REQ, so mem_addr shows pc when idle.
    assign mem_addr   = pc_q + ADDR_W'(byte_idx_q);
    assign mem_rd     = (state_q == ST_REQ);
    assign rw         = mem_rd ? RW_READ : RW_HOLD;
    assign ir_write   = (mem_rd && mem_ready && !pc_load) ? lane_strobe(byte_idx_q) : 4'b0000;
    assign fetch_done = (state_q == ST_DONE) && !pc_load;
    assign busy       = (state_q != ST_IDLE);
    assign pc         = pc_q;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Bench for ir_fetch_ctrl: directed vector table, reset/timeout sequences, randomized model check.
module tb_ir_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_req = 1'b0;
    logic        stall = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = '0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready = 1'b0;
    logic        rw;
    logic [3:0]  ir_write;
    logic        fetch_done;
    logic        busy;
    logic [15:0] pc;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [0:65535];
    logic [31:0] ir = '0;

    ir_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .stall(stall),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_ready(mem_ready), .rw(rw), .ir_write(ir_write),
        .fetch_done(fetch_done), .busy(busy), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Instruction register model: capture memory byte into the strobed lane.
    always @(posedge clk) begin
        if (!rw) begin
            for (int k = 0; k < 4; k++) begin
                if (ir_write[k]) ir[k*8 +: 8] <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        logic        req, stl, ld;
        logic [15:0] ldv;
        logic        rdy;
        logic        busy, rd;
        logic [3:0]  irw;
        logic [15:0] addr;
        logic        done;
        logic [15:0] pc;
        logic        chk_ir;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word_at(input logic [15:0] a);
        logic [15:0] a1, a2, a3;
        a1 = a + 16'd1; a2 = a + 16'd2; a3 = a + 16'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    task automatic add(input logic req, stl, ld, input logic [15:0] ldv, input logic rdy,
                       input logic b, rd, input logic [3:0] irw, input logic [15:0] addr,
                       input logic done, input logic [15:0] p,
                       input logic cir = 1'b0, input logic [31:0] eir = '0);
        vec_t v;
        v.req = req; v.stl = stl; v.ld = ld; v.ldv = ldv; v.rdy = rdy;
        v.busy = b; v.rd = rd; v.irw = irw; v.addr = addr; v.done = done; v.pc = p;
        v.chk_ir = cir; v.ir = eir;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {23'd0, busy, mem_rd, rw, ir_write, mem_addr, fetch_done, pc, fetch_err};
    endfunction

    function automatic logic [63:0] pack_exp(input logic b, rd, input logic [3:0] irw,
                                             input logic [15:0] addr, input logic done,
                                             input logic [15:0] p);
        return {23'd0, b, rd, ~rd, irw, addr, done, p, 1'b0};
    endfunction

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: k = -1 idle, 0..3 bytes already captured, 4 = complete.
    int          k;
    logic [15:0] mpc;

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            a = 16'(i);
            mem[i] = a[7:0] ^ a[15:8] ^ 8'h5A;
        end
        mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;

        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("reset_state", pack_out(), pack_exp(0, 0, 4'b0, 16'h0000, 0, 16'h0000));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        to_next();

        // Zero-wait fetch at 0
        add(1,0,0,16'h0,1, 0,0,4'h0,16'h0000,0,16'h0000);
        add(0,0,0,16'h0,1, 1,1,4'h1,16'h0000,0,16'h0000);
        add(0,0,0,16'h0,1, 1,1,4'h2,16'h0001,0,16'h0000);
        add(0,0,0,16'h0,1, 1,1,4'h4,16'h0002,0,16'h0000);
        add(0,0,0,16'h0,1, 1,1,4'h8,16'h0003,0,16'h0000);
        add(0,0,0,16'h0,1, 1,0,4'h0,16'h0000,1,16'h0000, 1, 32'h12345678);
        add(0,0,0,16'h0,1, 0,0,4'h0,16'h0004,0,16'h0004);
        // One wait state on byte 2
        add(1,0,0,16'h0,1, 0,0,4'h0,16'h0004,0,16'h0004);
        add(0,0,0,16'h0,1, 1,1,4'h1,16'h0004,0,16'h0004);
        add(0,0,0,16'h0,1, 1,1,4'h2,16'h0005,0,16'h0004);
        add(0,0,0,16'h0,0, 1,1,4'h0,16'h0006,0,16'h0004);
        add(0,0,0,16'h0,1, 1,1,4'h4,16'h0006,0,16'h0004);
        add(0,0,0,16'h0,1, 1,1,4'h8,16'h0007,0,16'h0004);
        add(0,0,0,16'h0,1, 1,0,4'h0,16'h0004,1,16'h0004, 1, word_at(16'h0004));
        add(0,0,0,16'h0,1, 0,0,4'h0,16'h0008,0,16'h0008);
        // Redirect during REQ byte 1
        add(1,0,0,16'h0,1, 0,0,4'h0,16'h0008,0,16'h0008);
        add(0,0,0,16'h0,1, 1,1,4'h1,16'h0008,0,16'h0008);
        add(0,0,1,16'h0123,1, 1,1,4'h0,16'h0009,0,16'h0008);
        add(0,0,0,16'h0,1, 0,0,4'h0,16'h0120,0,16'h0120);
        add(1,0,0,16'h0,1, 0,0,4'h0,16'h0120,0,16'h0120);
        add(0,0,0,16'h0,1, 1,1,4'h1,16'h0120,0,16'h0120);
        add(0,0,0,16'h0,1, 1,1,4'h2,16'h0121,0,16'h0120);
        add(0,0,0,16'h0,1, 1,1,4'h4,16'h0122,0,16'h0120);
        add(0,0,0,16'h0,1, 1,1,4'h8,16'h0123,0,16'h0120);
        add(0,0,0,16'h0,1, 1,0,4'h0,16'h0120,1,16'h0120, 1, word_at(16'h0120));
        add(0,0,0,16'h0,1, 0,0,4'h0,16'h0124,0,16'h0124);
        // Stall blocks start
        add(1,1,0,16'h0,1, 0,0,4'h0,16'h0124,0,16'h0124);
        add(1,1,0,16'h0,1, 0,0,4'h0,16'h0124,0,16'h0124);
        // Wrap at top of address space
        add(0,0,1,16'hFFFE,1, 0,0,4'h0,16'h0124,0,16'h0124);
        add(1,0,0,16'h0,1, 0,0,4'h0,16'hFFFC,0,16'hFFFC);
        add(0,0,0,16'h0,1, 1,1,4'h1,16'hFFFC,0,16'hFFFC);
        add(0,0,0,16'h0,1, 1,1,4'h2,16'hFFFD,0,16'hFFFC);
        add(0,0,0,16'h0,1, 1,1,4'h4,16'hFFFE,0,16'hFFFC);
        add(0,0,0,16'h0,1, 1,1,4'h8,16'hFFFF,0,16'hFFFC);
        add(0,0,0,16'h0,1, 1,0,4'h0,16'hFFFC,1,16'hFFFC, 1, word_at(16'hFFFC));
        add(0,0,0,16'h0,1, 0,0,4'h0,16'h0000,0,16'h0000);
        // Load beats fetch_req in IDLE
        add(1,0,1,16'h0040,1, 0,0,4'h0,16'h0000,0,16'h0000);
        add(0,0,0,16'h0,1, 0,0,4'h0,16'h0040,0,16'h0040);
        // Redirect in DONE beats the increment
        add(1,0,0,16'h0,1, 0,0,4'h0,16'h0040,0,16'h0040);
        add(0,0,0,16'h0,1, 1,1,4'h1,16'h0040,0,16'h0040);
        add(0,0,0,16'h0,1, 1,1,4'h2,16'h0041,0,16'h0040);
        add(0,0,0,16'h0,1, 1,1,4'h4,16'h0042,0,16'h0040);
        add(0,0,0,16'h0,1, 1,1,4'h8,16'h0043,0,16'h0040);
        add(0,0,1,16'h0207,1, 1,0,4'h0,16'h0040,0,16'h0040);
        add(0,0,0,16'h0,1, 0,0,4'h0,16'h0204,0,16'h0204);

        foreach (vecs[i]) begin
            fetch_req = vecs[i].req; stall = vecs[i].stl; pc_load = vecs[i].ld;
            pc_load_val = vecs[i].ldv; mem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_out(),
                  pack_exp(vecs[i].busy, vecs[i].rd, vecs[i].irw, vecs[i].addr,
                           vecs[i].done, vecs[i].pc));
            if (vecs[i].chk_ir) check($sformatf("vec%0d_ir", i), {32'd0, ir}, {32'd0, vecs[i].ir});
            to_next();
        end

        // Asynchronous reset while in REQ at byte 2
        fetch_req = 1'b0; stall = 1'b0; pc_load = 1'b1; pc_load_val = 16'h0080; mem_ready = 1'b1;
        to_next();
        pc_load = 1'b0; fetch_req = 1'b1;
        to_next();
        fetch_req = 1'b0;
        to_next();
        to_next();
        #2;
        check("pre_reset_addr", {48'd0, mem_addr}, 64'h0082);
        rst_n = 1'b0;
        #1;
        check("async_reset", pack_out(), pack_exp(0, 0, 4'b0, 16'h0000, 0, 16'h0000));
        @(negedge clk);
        rst_n = 1'b1;
        to_next();

        // Randomized run against the transaction model
        k = -1;
        mpc = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            logic        exp_inreq;
            logic [3:0]  exp_irw;
            logic [15:0] exp_addr;
            fetch_req   = ($urandom_range(0, 1) == 1);
            stall       = ($urandom_range(0, 3) == 0);
            pc_load     = ($urandom_range(0, 19) == 0);
            pc_load_val = 16'($urandom);
            mem_ready   = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            exp_inreq = (k >= 0 && k <= 3);
            exp_addr  = exp_inreq ? mpc + 16'(k) : mpc;
            exp_irw   = (exp_inreq && mem_ready && !pc_load) ? 4'(1 << k) : 4'b0000;
            check("random", pack_out(),
                  pack_exp(k != -1, exp_inreq, exp_irw, exp_addr, (k == 4) && !pc_load, mpc));
            if (k == 4 && !pc_load) check("random_ir", {32'd0, ir}, {32'd0, word_at(mpc)});
            if (pc_load) begin
                mpc = pc_load_val & 16'hFFFC;
                k = -1;
            end else if (k == -1) begin
                if (fetch_req && !stall) k = 0;
            end else if (k == 4) begin
                mpc = mpc + 16'd4;
                k = -1;
            end else if (mem_ready) begin
                k = k + 1;
            end
            to_next();
        end

`ifdef FETCH_TIMEOUT_EN
        begin
            int errs;
            errs = 0;
            fetch_req = 1'b0; stall = 1'b0; pc_load = 1'b1; pc_load_val = 16'h0200; mem_ready = 1'b0;
            to_next();
            pc_load = 1'b0; fetch_req = 1'b1;
            to_next();
            fetch_req = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (fetch_err) errs++;
                to_next();
            end
            check("timeout_pulses", 64'(errs), 64'd1);
            @(negedge clk);
            check("timeout_idle", {47'd0, busy, pc}, {47'd0, 1'b0, 16'h0200});
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
